input_conditioner: RTL

- Upstream stage that feeds the a/b inputs of the logic top.
- Takes two raw, asynchronous board inputs (pushbuttons/switches) and synchronises each into the clk domain.
- Debounces each channel independently and emits clean levels a/b plus one-cycle rise/fall pulses.
- The top's and_o/xor_o are therefore driven from glitch-free, registered signals.

---
 rtl/input_conditioner.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Purpose: synchronise and debounce two raw board inputs into clean levels plus rise/fall pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES rising edges from raw step to output change.
// Backpressure: none; both inputs are sampled every cycle.
//
// Ports:
//   clk                  system clock, all logic on rising edge
//   rst_n                synchronous active-low reset
//   btn_a_raw, btn_b_raw raw asynchronous inputs
//   a, b                 debounced outputs (levels, or toggles when INPUT_COND_TOGGLE_EN is defined)
//   a_rise/a_fall        one-cycle pulses on debounced edges of channel a
//   b_rise/b_fall        one-cycle pulses on debounced edges of channel b
//
// Optional build: define INPUT_COND_TOGGLE_EN to make a/b invert on each
// debounced rising commit instead of following the debounced level.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_a_raw,
  input  logic btn_b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("input_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
    $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic [1:0] raw;
  logic [1:0] out_lvl;
  logic [1:0] rise;
  logic [1:0] fall;

  assign raw = {btn_b_raw, btn_a_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q;
    logic                   rise_q, fall_q;
    logic                   commit;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[ch]};
      end
    end

    // The counter holds the number of consecutive differing samples seen so
    // far; commit fires on the DEBOUNCE_CYCLES-th one, so cnt never reaches
    // DEBOUNCE_CYCLES and cannot wrap.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      case (state_q)
        STABLE: begin
          if (s != level_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              commit = 1'b1;
            end else begin
              cnt_d   = CW'(1);
              state_d = PENDING;
            end
          end
        end
        PENDING: begin
          if (s == level_q) begin
            cnt_d   = '0;
            state_d = STABLE;
          end else if (cnt_q == CNT_LAST) begin
            commit = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = STABLE;
        end
      endcase
      if (commit) begin
        cnt_d   = '0;
        state_d = STABLE;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= STABLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        // Pulses are registered alongside the level so they line up with it.
        rise_q  <= commit & s;
        fall_q  <= commit & ~s;
        if (commit) begin
          level_q <= s;
        end
      end
    end

`ifdef INPUT_COND_TOGGLE_EN
    logic tog_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        tog_q <= 1'b0;
      end else if (commit && s) begin
        tog_q <= ~tog_q;
      end
    end

    assign out_lvl[ch] = tog_q;
`else
    assign out_lvl[ch] = level_q;
`endif

    assign rise[ch] = rise_q;
    assign fall[ch] = fall_q;
  end

  assign a      = out_lvl[0];
  assign b      = out_lvl[1];
  assign a_rise = rise[0];
  assign a_fall = fall[0];
  assign b_rise = rise[1];
  assign b_fall = fall[1];

endmodule
